// File: rtl/instr_encoder.sv
// MIPS instruction encoder / program loader: packs one instruction per handshake
// and streams the words to consecutive instruction-memory addresses.
module instr_encoder #(
   parameter logic [31:0] BASE  = 32'h0000_0000,
   parameter int          DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   input  logic        last,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wd,
   output logic [10:0] count,
   output logic        done,
   output logic        err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;
   localparam logic [11:0] DEPTH_W = 12'(DEPTH);

   logic [1:0]  state;
   logic [31:0] nxt_addr;
   logic [31:0] word;
   logic        legal;
   logic        hs;
   logic [11:0] used;

   // Words already committed plus the one sitting in the write register.
   assign used     = {1'b0, count} + {11'd0, imem_we};
   assign in_ready = (state == S_RUN) && (used < DEPTH_W);
   assign hs       = in_valid & in_ready;
   assign done     = (state == S_DONE);
   assign err      = (state == S_ERR);

   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (kind)
         4'd0:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
         4'd1:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
         4'd2:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
         4'd3:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
         4'd4:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
         4'd5:    word = {6'b100011, rs, rt, imm};
         4'd6:    word = {6'b101011, rs, rt, imm};
         4'd7:    word = {6'b000100, rs, rt, imm};
         4'd8:    word = {6'b001000, rs, rt, imm};
         4'd9:    word = {6'b000010, target};
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         imem_we   <= 1'b0;
         imem_addr <= BASE;
         imem_wd   <= '0;
         count     <= '0;
         nxt_addr  <= BASE;
      end else begin
         imem_we <= hs & legal;
         if (imem_we && (count < DEPTH_W[10:0]))
            count <= count + 11'd1;
         if (hs && legal) begin
            imem_addr <= nxt_addr;
            imem_wd   <= word;
            nxt_addr  <= nxt_addr + 32'd4;
         end
         case (state)
            S_RUN: begin
               if (hs) begin
                  if (!legal)
                     state <= S_ERR;
                  else if (last)
                     state <= S_DONE;
                  else if (used + 12'd1 == DEPTH_W)
                     state <= S_ERR;
               end
            end
            default: begin
               // A fresh load discards any stale count from the previous one.
               if (start) begin
                  state    <= S_RUN;
                  count    <= '0;
                  nxt_addr <= BASE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: three instances (default, DEPTH=4,
// wrapping BASE) share the instruction bus; one is selected at a time.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [3:0]  kind;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic [25:0] target;
   logic        last;

   logic        st   [3];
   logic        rdy  [3];
   logic        we   [3];
   logic [31:0] addr [3];
   logic [31:0] wd   [3];
   logic [10:0] cnt  [3];
   logic        dn   [3];
   logic        er   [3];

   int sel = 0;
   int checks = 0;
   int failures = 0;
   logic [63:0] q[$];

   always #5 clk = ~clk;

   instr_encoder #(.BASE(32'h0000_0000), .DEPTH(64)) u0 (
      .clk(clk), .reset(reset), .start(st[0]), .in_valid(in_valid), .in_ready(rdy[0]),
      .kind(kind), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .last(last),
      .imem_we(we[0]), .imem_addr(addr[0]), .imem_wd(wd[0]), .count(cnt[0]),
      .done(dn[0]), .err(er[0]));

   instr_encoder #(.BASE(32'h0000_0000), .DEPTH(4)) u1 (
      .clk(clk), .reset(reset), .start(st[1]), .in_valid(in_valid), .in_ready(rdy[1]),
      .kind(kind), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .last(last),
      .imem_we(we[1]), .imem_addr(addr[1]), .imem_wd(wd[1]), .count(cnt[1]),
      .done(dn[1]), .err(er[1]));

   instr_encoder #(.BASE(32'hFFFF_FFF8), .DEPTH(64)) u2 (
      .clk(clk), .reset(reset), .start(st[2]), .in_valid(in_valid), .in_ready(rdy[2]),
      .kind(kind), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .last(last),
      .imem_we(we[2]), .imem_addr(addr[2]), .imem_wd(wd[2]), .count(cnt[2]),
      .done(dn[2]), .err(er[2]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every write strobe of the selected instance must match the queue head.
   always @(negedge clk) begin
      if (we[sel] === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: addr 0x%0h wd 0x%0h, none expected", addr[sel], wd[sel]);
         end else begin
            logic [63:0] e;
            e = q.pop_front();
            chk("write_addr", {32'd0, addr[sel]}, {32'd0, e[63:32]});
            chk("write_wd",   {32'd0, wd[sel]},   {32'd0, e[31:0]});
         end
      end
   end

   task automatic do_start(input int n);
      st[n] = 1'b1;
      @(posedge clk); #1;
      st[n] = 1'b0;
   endtask

   task automatic send(input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg,
                       input logic l, input logic [31:0] ew, input logic [31:0] ea,
                       input bit legal);
      bit ok;
      ok = 1'b0;
      kind = k; rs = s; rt = t; rd = d; imm = i; target = tg; last = l;
      in_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rdy[sel] === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL handshake_timeout: in_ready 0 expected 1");
      end else if (legal) begin
         q.push_back({ea, ew});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic reject(input string nm);
      kind = 4'd8; rs = 5'd1; rt = 5'd2; imm = 16'h0005; last = 1'b0;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk(nm, {63'd0, rdy[sel]}, 64'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; kind = '0; rs = '0; rt = '0; rd = '0;
      imm = '0; target = '0; last = 1'b0;
      st[0] = 1'b0; st[1] = 1'b0; st[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", {63'd0, rdy[0]}, 64'd0);
      chk("rst_we",    {63'd0, we[0]},  64'd0);
      chk("rst_addr",  {32'd0, addr[0]}, 64'd0);
      chk("rst_wd",    {32'd0, wd[0]},   64'd0);
      chk("rst_count", {53'd0, cnt[0]},  64'd0);
      chk("rst_done",  {63'd0, dn[0]},   64'd0);
      chk("rst_err",   {63'd0, er[0]},   64'd0);
      chk("rst_addr_wrapbase", {32'd0, addr[2]}, 64'hFFFF_FFF8);
      @(posedge clk); #1;

      // single add, last
      sel = 0;
      do_start(0);
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_1820, 32'h0, 1'b1);
      @(negedge clk);
      chk("t1_done_n1", {63'd0, dn[0]}, 64'd1);
      chk("t1_ready_n1", {63'd0, rdy[0]}, 64'd0);
      @(posedge clk); @(negedge clk);
      chk("t1_done", {63'd0, dn[0]}, 64'd1);
      chk("t1_count", {53'd0, cnt[0]}, 64'd1);
      chk("t1_err", {63'd0, er[0]}, 64'd0);
      @(posedge clk); #1;

      // back-to-back stream; unused fields carry junk
      do_start(0);
      send(4'd5, 5'd0, 5'd2, 5'd7, 16'h0050, 26'h3FF_FFFF, 1'b0, 32'h8C02_0050, 32'h0, 1'b1);
      send(4'd7, 5'd1, 5'd2, 5'd9, 16'hFFFF, 26'h0, 1'b0, 32'h1022_FFFF, 32'h4, 1'b1);
      send(4'd9, 5'd3, 5'd4, 5'd5, 16'hABCD, 26'h000_0011, 1'b1, 32'h0800_0011, 32'h8, 1'b1);
      idle(2);
      @(negedge clk);
      chk("t2_done", {63'd0, dn[0]}, 64'd1);
      chk("t2_count", {53'd0, cnt[0]}, 64'd3);
      @(posedge clk); #1;

      // illegal kind as second word
      do_start(0);
      send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h0022_1824, 32'h0, 1'b1);
      send(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      idle(2);
      @(negedge clk);
      chk("t3_err", {63'd0, er[0]}, 64'd1);
      chk("t3_done", {63'd0, dn[0]}, 64'd0);
      chk("t3_count", {53'd0, cnt[0]}, 64'd1);
      chk("t3_ready", {63'd0, rdy[0]}, 64'd0);
      @(posedge clk); #1;
      do_start(0);
      @(negedge clk);
      chk("t3_err_clr", {63'd0, er[0]}, 64'd0);
      chk("t3_count_clr", {53'd0, cnt[0]}, 64'd0);
      @(posedge clk); #1;
      send(4'd6, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1, 32'hAFA8_0004, 32'h0, 1'b1);
      idle(3);

      // overflow at DEPTH=4
      sel = 1;
      do_start(1);
      for (int i = 0; i < 4; i++)
         send(4'd8, 5'd1, 5'd2, 5'd0, 16'(i), 26'h0, 1'b0,
              32'h2022_0000 + 32'(i), 32'(4 * i), 1'b1);
      reject("t4_fifth_ready");
      @(negedge clk);
      chk("t4_err", {63'd0, er[1]}, 64'd1);
      chk("t4_count", {53'd0, cnt[1]}, 64'd4);
      @(posedge clk); #1;
      idle(2);

      // reset in the cycle after a handshake
      sel = 0;
      do_start(0);
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h0022_1820, 32'h0, 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_we", {63'd0, we[0]}, 64'd0);
      chk("t5_ready", {63'd0, rdy[0]}, 64'd0);
      chk("t5_addr", {32'd0, addr[0]}, 64'd0);
      chk("t5_wd", {32'd0, wd[0]}, 64'd0);
      chk("t5_count", {53'd0, cnt[0]}, 64'd0);
      chk("t5_err_u1", {63'd0, er[1]}, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      do_start(0);
      send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_1822, 32'h0, 1'b1);
      idle(3);

      // address wrap past 2^32
      sel = 2;
      do_start(2);
      send(4'd3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 32'h0085_3025, 32'hFFFF_FFF8, 1'b1);
      send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h0022_1822, 32'hFFFF_FFFC, 1'b1);
      send(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0022_182A, 32'h0000_0000, 1'b1);
      idle(3);
      @(negedge clk);
      chk("t6_done", {63'd0, dn[2]}, 64'd1);
      chk("t6_count", {53'd0, cnt[2]}, 64'd3);
      chk("queue_drained", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
